homework1_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises the 4-input combinational function block (out = x3·x1 + x3·x2·x1'). On a start request it drives input codes 0..2^N_IN-1 in order and holds each code for a settle window. It samples the function output for every code, builds the full truth table and compares it against a golden mask. It replaces the hand-written time-stepped stimulus with a synthesizable self-check, and sits between a host/test harness and the function block.

---
 rtl/homework1_pkg.sv | 15 +
 rtl/homework1_settle_timer.sv | 37 +++
 rtl/homework1_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_homework1_sweep_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/homework1_pkg.sv
// Shared types and defaults for the truth-table sweep sequencer.
package homework1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int              N_IN_DEFAULT     = 4;
  localparam int              N_CODES          = 2 ** N_IN_DEFAULT;
  localparam logic [15:0]     EXPECTED_DEFAULT = 16'hFC00;

endpackage

// File: rtl/homework1_settle_timer.sv
// Settle-window counter: counts enabled cycles from a clear and flags the last
// hold cycle. SETTLE=0 means the terminal count is always asserted.
module homework1_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (SETTLE == 0) ? 1'b1 : (cnt_q == TC_VAL);

endmodule

// File: rtl/homework1_sweep_ctrl.sv
// Sweeps every input code of a combinational block, captures its truth table
// and compares it against a golden mask.
module homework1_sweep_ctrl
  import homework1_pkg::*;
#(
  parameter int                  N_IN     = N_IN_DEFAULT,
  parameter int                  SETTLE   = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED = EXPECTED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        ones_count,
  output logic                 mismatch_valid,
  output logic [N_IN-1:0]      mismatch_idx
);

  localparam int              NUM_CODES  = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST_CODE  = N_IN'(NUM_CODES - 1);
  localparam state_e          CODE_ENTRY = (SETTLE == 0) ? SAMPLE : HOLD;

  state_e                 state_q;
  logic [N_IN-1:0]        code_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [NUM_CODES-1:0]   tt_q;
  logic [N_IN:0]          ones_q;
  logic                   mv_q;
  logic [N_IN-1:0]        midx_q;

  logic                   settle_tc;
  logic                   miss;

  homework1_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (settle_tc | abort),
    .en_i  (state_q == HOLD),
    .tc_o  (settle_tc)
  );

  assign miss = dut_out ^ EXPECTED[code_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
      mv_q    <= 1'b0;
      midx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= CODE_ENTRY;
            code_q  <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
            mv_q    <= 1'b0;
            midx_q  <= '0;
          end
        end
        HOLD: begin
          if (abort) begin
            state_q <= IDLE;
            code_q  <= '0;
            busy_q  <= 1'b0;
          end else if (settle_tc) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          // An abort on the sample edge discards that code's result.
          if (abort) begin
            state_q <= IDLE;
            code_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            tt_q[code_q] <= dut_out;
            ones_q       <= ones_q + (N_IN + 1)'(dut_out);
            if (miss && !mv_q) begin
              mv_q   <= 1'b1;
              midx_q <= code_q;
            end
            if (code_q == LAST_CODE) begin
              state_q <= FINISH;
              code_q  <= '0;
              done_q  <= 1'b1;
              pass_q  <= !(mv_q || miss);
            end else begin
              state_q <= CODE_ENTRY;
              code_q  <= code_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in         = code_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth_table    = tt_q;
  assign ones_count     = ones_q;
  assign mismatch_valid = mv_q;
  assign mismatch_idx   = midx_q;

endmodule

// File: tb/tb_homework1_sweep_ctrl.sv
// Randomized bench: two sequencers (settle 2 and settle 0) sweep a modelled
// function block with injectable faults; results are checked against a model.
module tb_homework1_sweep_ctrl;

  localparam int NC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start   [2];
  logic        abort   [2];
  logic [3:0]  dut_in  [2];
  logic        dut_out [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic [15:0] tt      [2];
  logic [4:0]  ones    [2];
  logic        mv      [2];
  logic [3:0]  midx    [2];
  logic [15:0] fault   [2];
  logic [15:0] expv;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic fb(input logic [3:0] c);
    return (c[3] & c[1]) | (c[3] & c[2] & ~c[1]);
  endfunction

  assign dut_out[0] = fb(dut_in[0]) ^ fault[0][dut_in[0]];
  assign dut_out[1] = fb(dut_in[1]) ^ fault[1][dut_in[1]];

  homework1_sweep_ctrl #(.N_IN(4), .SETTLE(2), .EXPECTED(16'hFC00)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .truth_table(tt[0]), .ones_count(ones[0]),
    .mismatch_valid(mv[0]), .mismatch_idx(midx[0])
  );

  homework1_sweep_ctrl #(.N_IN(4), .SETTLE(0), .EXPECTED(16'hFC00)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .truth_table(tt[1]), .ones_count(ones[1]),
    .mismatch_valid(mv[1]), .mismatch_idx(midx[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: the first ncap codes of the faulted function, scored against the golden mask.
  task automatic ref_sweep(input int i, input int ncap, output logic [15:0] r_tt,
                           output int r_ones, output logic r_mv, output logic [3:0] r_idx);
    logic o;
    r_tt = '0; r_ones = 0; r_mv = 1'b0; r_idx = '0;
    for (int k = 0; k < ncap; k++) begin
      o = fb(k[3:0]) ^ fault[i][k];
      r_tt[k] = o;
      r_ones += int'(o);
      if (!r_mv && (o != expv[k])) begin
        r_mv  = 1'b1;
        r_idx = k[3:0];
      end
    end
  endtask

  task automatic run_sweep(input int i, input logic [15:0] fm, input int restart_cyc, input int abort_cyc);
    int s, lat, cyc, bad_in, r_ones, ncap;
    logic [15:0] r_tt;
    logic r_mv, seen_done;
    logic [3:0] r_idx;
    s   = (i == 0) ? 2 : 0;
    lat = NC * (s + 1) + 1;
    fault[i] = fm;
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    cyc = 1; bad_in = 0;
    check("busy_after_start", busy[i], 1);
    forever begin
      if (cyc == abort_cyc + 1) break;
      if (done[i]) break;
      if (cyc > lat + 5) break;
      if (cyc < lat && bad_in == 0 && dut_in[i] !== 4'((cyc - 1) / (s + 1))) bad_in = cyc;
      if (cyc == restart_cyc) start[i] = 1'b1;
      if (cyc == abort_cyc) abort[i] = 1'b1;
      @(posedge clk);
      #1;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      cyc++;
    end
    check("dut_in_sequence_bad_cycle", bad_in, 0);
    if (abort_cyc > 0) begin
      ncap = (abort_cyc - 1) / (s + 1);
      ref_sweep(i, ncap, r_tt, r_ones, r_mv, r_idx);
      check("abort_busy", busy[i], 0);
      check("abort_dut_in", dut_in[i], 0);
      check("abort_tt", tt[i], r_tt);
      check("abort_ones", ones[i], r_ones);
      check("abort_pass", pass[i], 0);
      seen_done = done[i];
      repeat (5) begin
        @(posedge clk);
        #1;
        seen_done |= done[i];
      end
      check("abort_no_done", seen_done, 0);
      $display("inst %0d abort at cycle %0d fault=%h tt=%h ones=%0d", i, abort_cyc, fm, tt[i], ones[i]);
    end else begin
      ref_sweep(i, NC, r_tt, r_ones, r_mv, r_idx);
      check("done_cycle", cyc, lat);
      check("tt", tt[i], r_tt);
      check("ones", ones[i], r_ones);
      check("pass", pass[i], !r_mv);
      check("mismatch_valid", mv[i], r_mv);
      check("mismatch_idx", midx[i], r_idx);
      check("busy_in_finish", busy[i], 1);
      @(posedge clk);
      #1;
      check("done_one_cycle", done[i], 0);
      check("busy_after_finish", busy[i], 0);
      check("dut_in_idle", dut_in[i], 0);
      check("tt_held", tt[i], r_tt);
      $display("inst %0d sweep fault=%h done_cycle=%0d tt=%h ones=%0d pass=%0b idx=%0d",
               i, fm, cyc, tt[i], ones[i], pass[i], midx[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy[0], 0);
    check({tag, "_done"}, done[0], 0);
    check({tag, "_pass"}, pass[0], 0);
    check({tag, "_dut_in"}, dut_in[0], 0);
    check({tag, "_tt"}, tt[0], 0);
    check({tag, "_ones"}, ones[0], 0);
    check({tag, "_mv"}, mv[0], 0);
    check({tag, "_midx"}, midx[0], 0);
  endtask

  initial begin
    logic [15:0] tt_before;
    expv = 16'hFC00;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; fault[i] = '0;
    end
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 16'h0000, -1, -1);
    run_sweep(0, 16'h0200, -1, -1);
    run_sweep(0, 16'h0000, -1, 16);
    run_sweep(0, 16'($urandom), -1, 12);
    run_sweep(0, 16'h0000, 22, -1);

    // start and abort together in IDLE: request refused, results kept
    tt_before = tt[0];
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_busy", busy[0], 0);
    check("start_abort_tt", tt[0], tt_before);
    repeat (2) @(posedge clk);
    #1;
    check("start_abort_done", done[0], 0);
    $display("inst 0 start+abort in idle busy=%0b", busy[0]);

    // asynchronous reset mid-cycle while sampling code 12
    fault[0] = '0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (38) @(posedge clk);
    #3;
    check("pre_reset_code", dut_in[0], 12);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    $display("inst 0 async reset during code 12 busy=%0b", busy[0]);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 16'h0000, -1, -1);

    run_sweep(1, 16'h0000, -1, -1);
    for (int n = 0; n < 4; n++) begin
      run_sweep(0, 16'($urandom) & 16'($urandom), -1, -1);
      run_sweep(1, 16'($urandom), -1, -1);
    end
    run_sweep(1, 16'($urandom), -1, int'($urandom_range(2, 15)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
